// File: rtl/if_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_stage_pkg
// Shared CPU definitions used by the fetch / IF-ID stage:
//   - datapath and register-address widths
//   - NOP instruction encoding
//   - source-register field positions inside a 16-bit instruction word
//   - fetch-stage FSM state encoding
//   - IF/ID pipeline register record and field-extraction helpers
// -----------------------------------------------------------------------------
package if_id_stage_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned REG_AW = 4;

  // All-zero word is the architectural NOP.
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

  // Source register fields: rn1 = instr[7:4], rn2 = instr[3:0].
  localparam int unsigned RN1_LSB = 4;
  localparam int unsigned RN2_LSB = 0;

  // Saturation ceiling of the stall counter.
  localparam logic [XLEN-1:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  function automatic logic [REG_AW-1:0] rn1_of(input logic [XLEN-1:0] instr);
    return instr[RN1_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] rn2_of(input logic [XLEN-1:0] instr);
    return instr[RN2_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// 16-bit program counter with load / increment / hold.
// Priority: load > inc > hold. Increment wraps 16'hFFFF -> 16'h0000.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (PC -> 0)
//   load         : load load_value on the next edge
//   load_value   : target address
//   inc          : advance PC by one word
//   pc           : current PC
// -----------------------------------------------------------------------------
module pc_reg
  import if_id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_value,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_value_reg;
  logic [XLEN-1:0] pc_value_next;

  always_comb begin
    pc_value_next = pc_value_reg;
    if (load) begin
      pc_value_next = load_value;
    end else if (inc) begin
      // Natural modulo-2^16 wrap of the adder.
      pc_value_next = pc_value_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_value_reg <= '0;
    end else begin
      pc_value_reg <= pc_value_next;
    end
  end

  assign pc = pc_value_reg;

endmodule

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Instruction fetch PC plus the IF/ID pipeline register, steered by the
// hazard unit (stall) and by branch resolution in EX (flush).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   pc_write          : 1 = advance PC, 0 = hold PC (stall)
//   IFIDWrite, EnIW   : IF/ID loads only when both are 1
//   ST                : hazard stall flag, forces an ID/EX bubble
//   flush             : taken branch/jump, redirect PC and squash IF/ID
//   branch_target     : redirect address used when flush = 1
//   instr_in          : instruction memory data for pc_out (combinational)
//   pc_out            : current fetch address
//   if_id_instr/pc    : latched instruction and its address
//   if_id_valid       : latched instruction is real (not squashed)
//   if_id_rn1/rn2     : source register fields of the latched instruction
//   idex_bubble       : zero the ID/EX control word this cycle
//   stall_cnt         : saturating count of stall cycles
// -----------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              IFIDWrite,
  input  logic              ST,
  input  logic              EnIW,
  input  logic              flush,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   instr_in,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   if_id_instr,
  output logic [XLEN-1:0]   if_id_pc,
  output logic              if_id_valid,
  output logic [REG_AW-1:0] if_id_rn1,
  output logic [REG_AW-1:0] if_id_rn2,
  output logic              idex_bubble,
  output logic [XLEN-1:0]   stall_cnt
);

  // ---------------------------------------------------------------------------
  // Program counter: flush redirect beats stall/advance.
  // ---------------------------------------------------------------------------
  pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (flush),
    .load_value (branch_target),
    .inc        (pc_write),
    .pc         (pc_out)
  );

  // ---------------------------------------------------------------------------
  // Fetch FSM. FLUSH lasts one cycle unless flush is held; a flush arriving
  // together with a stall request is treated purely as a flush.
  // ---------------------------------------------------------------------------
  if_state_e state_reg;
  if_state_e state_next;

  always_comb begin
    state_next = S_RUN;
    if (flush) begin
      state_next = S_FLUSH;
    end else if (!pc_write) begin
      state_next = S_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: counts edges that enter (or remain in) STALL, saturating.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] stall_cnt_reg;
  logic [XLEN-1:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if ((state_next == S_STALL) && (stall_cnt_reg != STALL_CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // ---------------------------------------------------------------------------
  // IF/ID register. On flush only instr/valid are squashed; the PC field keeps
  // its old value since nothing downstream consumes it for an invalid slot.
  // ---------------------------------------------------------------------------
  if_id_t if_id_reg;
  if_id_t if_id_next;

  always_comb begin
    if_id_next = if_id_reg;
    if (flush) begin
      if_id_next.instr = NOP_INSTR;
      if_id_next.valid = 1'b0;
    end else if (IFIDWrite && EnIW) begin
      if_id_next.instr = instr_in;
      if_id_next.pc    = pc_out;
      if_id_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_reg.instr <= NOP_INSTR;
      if_id_reg.pc    <= '0;
      if_id_reg.valid <= 1'b0;
    end else begin
      if_id_reg <= if_id_next;
    end
  end

  assign if_id_instr = if_id_reg.instr;
  assign if_id_pc    = if_id_reg.pc;
  assign if_id_valid = if_id_reg.valid;
  assign if_id_rn1   = rn1_of(if_id_reg.instr);
  assign if_id_rn2   = rn2_of(if_id_reg.instr);

  // Bubble whenever the hazard unit stalls, the slot is empty, or a flush has
  // just squashed the pipeline.
  assign idex_bubble = ST || !if_id_reg.valid || (state_reg == S_FLUSH);

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Directed vector table, hand-written multi-cycle sequences (saturation, PC
// wrap, asynchronous reset mid-stall) and randomized traffic checked against
// a behavioural model of the fetch/IF-ID rules.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, IFIDWrite, ST, EnIW, flush;
  logic [15:0] branch_target, instr_in;
  logic [15:0] pc_out, if_id_instr, if_id_pc, stall_cnt;
  logic        if_id_valid, idex_bubble;
  logic [3:0]  if_id_rn1, if_id_rn2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Instruction memory image: imem[a] = a + 16'h1000.
  function automatic logic [15:0] imem(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  assign instr_in = imem(pc_out);

  if_id_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .IFIDWrite     (IFIDWrite),
    .ST            (ST),
    .EnIW          (EnIW),
    .flush         (flush),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .if_id_rn1     (if_id_rn1),
    .if_id_rn2     (if_id_rn2),
    .idex_bubble   (idex_bubble),
    .stall_cnt     (stall_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int unsigned m_pc, m_instr, m_ipc, m_cnt;
  bit          m_valid, m_just_flushed;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    m_valid = 0; m_just_flushed = 0;
  endtask

  // One clock edge worth of the fetch rules, using the inputs present at it.
  task automatic model_edge();
    int unsigned fetched;
    fetched = 32'(imem(16'(m_pc)));
    if (flush) begin
      m_pc = 32'(branch_target);
      m_instr = 0;
      m_valid = 0;
      m_just_flushed = 1;
    end else begin
      if (IFIDWrite && EnIW) begin
        m_instr = fetched;
        m_ipc   = m_pc;
        m_valid = 1;
      end
      if (pc_write) m_pc = (m_pc + 1) % 65536;
      else if (m_cnt < 65535) m_cnt = m_cnt + 1;
      m_just_flushed = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_regs();
    chk("pc_out",      32'(pc_out),      m_pc);
    chk("if_id_instr", 32'(if_id_instr), m_instr);
    chk("if_id_pc",    32'(if_id_pc),    m_ipc);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("if_id_rn1",   32'(if_id_rn1),   (m_instr >> 4) & 32'hF);
    chk("if_id_rn2",   32'(if_id_rn2),   m_instr & 32'hF);
    chk("stall_cnt",   32'(stall_cnt),   m_cnt);
  endtask

  task automatic check_bubble();
    chk("idex_bubble", 32'(idex_bubble), 32'(ST || !m_valid || m_just_flushed));
  endtask

  task automatic set_in(input bit fl, input logic [15:0] bt, input bit pw,
                        input bit iw, input bit en, input bit st);
    flush = fl; branch_target = bt; pc_write = pw; IFIDWrite = iw; EnIW = en; ST = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 16'h0, 1, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          fl;
    logic [15:0] bt;
    bit          pw, iw, en, st;
    logic [15:0] e_pc, e_instr, e_ipc;
    bit          e_valid, e_bub;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    //          fl bt        pw iw en st  pc        instr     ipc       v  b  cnt
    vecs[0]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0001, 16'h1000, 16'h0000, 1, 0, 16'd0};
    vecs[1]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0002, 16'h1001, 16'h0001, 1, 0, 16'd0};
    vecs[2]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0003, 16'h1002, 16'h0002, 1, 0, 16'd0};
    vecs[3]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0004, 16'h1003, 16'h0003, 1, 0, 16'd0};
    vecs[4]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0005, 16'h1004, 16'h0004, 1, 0, 16'd0};
    // load-use stall at pc 5
    vecs[5]  = '{0, 16'h0000, 0, 0, 1, 1, 16'h0005, 16'h1004, 16'h0004, 1, 1, 16'd1};
    vecs[6]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0006, 16'h1005, 16'h0005, 1, 0, 16'd1};
    // branch redirect
    vecs[7]  = '{1, 16'h0040, 1, 1, 1, 0, 16'h0040, 16'h0000, 16'h0005, 0, 1, 16'd1};
    vecs[8]  = '{0, 16'h0000, 1, 1, 1, 0, 16'h0041, 16'h1040, 16'h0040, 1, 0, 16'd1};
    // flush together with stall: flush wins, no count
    vecs[9]  = '{1, 16'h0080, 0, 0, 1, 1, 16'h0080, 16'h0000, 16'h0040, 0, 1, 16'd1};
    vecs[10] = '{0, 16'h0000, 1, 1, 1, 0, 16'h0081, 16'h1080, 16'h0080, 1, 0, 16'd1};
    // EnIW low holds IF/ID while PC advances
    vecs[11] = '{0, 16'h0000, 1, 1, 0, 0, 16'h0082, 16'h1080, 16'h0080, 1, 0, 16'd1};
    // redirect to top of memory, then wrap on advance
    vecs[12] = '{1, 16'hFFFF, 1, 1, 1, 0, 16'hFFFF, 16'h0000, 16'h0080, 0, 1, 16'd1};
    vecs[13] = '{0, 16'h0000, 1, 1, 1, 0, 16'h0000, 16'h0FFF, 16'hFFFF, 1, 0, 16'd1};
    // PC hold with IF/ID loading
    vecs[14] = '{0, 16'h0000, 0, 1, 1, 0, 16'h0000, 16'h1000, 16'h0000, 1, 0, 16'd2};
    vecs[15] = '{0, 16'h0000, 1, 0, 1, 0, 16'h0001, 16'h1000, 16'h0000, 1, 0, 16'd2};
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 16'h0, 1, 1, 1, 0);
    #1;
    do_reset();

    // Reset state
    chk("rst pc_out",      32'(pc_out),      32'h0);
    chk("rst if_id_instr", 32'(if_id_instr), 32'h0);
    chk("rst if_id_pc",    32'(if_id_pc),    32'h0);
    chk("rst if_id_valid", 32'(if_id_valid), 32'h0);
    chk("rst stall_cnt",   32'(stall_cnt),   32'h0);
    chk("rst idex_bubble", 32'(idex_bubble), 32'h1);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].fl, vecs[i].bt, vecs[i].pw, vecs[i].iw, vecs[i].en, vecs[i].st);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc_out", i),      32'(pc_out),      32'(vecs[i].e_pc));
      chk($sformatf("v%0d if_id_instr", i), 32'(if_id_instr), 32'(vecs[i].e_instr));
      chk($sformatf("v%0d if_id_pc", i),    32'(if_id_pc),    32'(vecs[i].e_ipc));
      chk($sformatf("v%0d if_id_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d if_id_rn1", i),   32'(if_id_rn1),   32'(vecs[i].e_instr[7:4]));
      chk($sformatf("v%0d if_id_rn2", i),   32'(if_id_rn2),   32'(vecs[i].e_instr[3:0]));
      chk($sformatf("v%0d idex_bubble", i), 32'(idex_bubble), 32'(vecs[i].e_bub));
      chk($sformatf("v%0d stall_cnt", i),   32'(stall_cnt),   32'(vecs[i].e_cnt));
    end

    // Long stall: counter saturates at 16'hFFFF
    do_reset();
    set_in(0, 16'h0, 0, 0, 1, 0);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check_regs();
    chk("sat pre-max", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("sat max", 32'(stall_cnt), 32'hFFFF);
      check_regs();
    end

    // PC wrap after redirect to 16'hFFFF, counter stays saturated
    set_in(1, 16'hFFFF, 1, 1, 1, 0);
    @(posedge clk); model_edge(); #1; check_regs();
    set_in(0, 16'h0, 1, 1, 1, 0);
    @(posedge clk); model_edge(); #1; check_regs();
    chk("wrap pc_out", 32'(pc_out), 32'h0);

    // Asynchronous reset mid-stall, between clock edges
    set_in(0, 16'h0, 0, 0, 1, 1);
    @(posedge clk); model_edge();
    #3 rst_n = 1'b0;
    #1;
    chk("async pc_out",      32'(pc_out),      32'h0);
    chk("async if_id_instr", 32'(if_id_instr), 32'h0);
    chk("async if_id_pc",    32'(if_id_pc),    32'h0);
    chk("async if_id_valid", 32'(if_id_valid), 32'h0);
    chk("async stall_cnt",   32'(stall_cnt),   32'h0);
    chk("async idex_bubble", 32'(idex_bubble), 32'h1);
    set_in(0, 16'h0, 1, 1, 1, 0);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("first fetch pc_out", 32'(pc_out),      32'h1);
    chk("first fetch instr",  32'(if_id_instr), 32'h1000);
    chk("first fetch ipc",    32'(if_id_pc),    32'h0);
    chk("first fetch valid",  32'(if_id_valid), 32'h1);
    model_edge();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 9) == 0, 16'($urandom),
             $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0);
      #1;
      check_bubble();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have `clk`, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have `rst_n`, input, 1, asynchronous active-low reset.
REQ-003 SHALL have `pc_write`, input, 1, hazard-unit PC update enable (0 = hold PC).
REQ-004 SHALL have `IFIDWrite`, input, 1, hazard-unit IF/ID load enable (0 = hold IF/ID).
REQ-005 SHALL have `ST`, input, 1, hazard-unit stall flag (1 = inject bubble into ID/EX).
REQ-006 SHALL have `EnIW`, input, 1, instruction-word write enable; IF/ID loads only when `IFIDWrite` && `EnIW`.
REQ-007 SHALL have `flush`, input, 1, taken branch/jump resolved in EX.
REQ-008 SHALL have `branch_target`, input, 16, next PC when `flush`=1.
REQ-009 SHALL have `instr_in`, input, 16, instruction memory read data, combinational from `pc_out`.
REQ-010 SHALL have `pc_out`, output, 16, registered fetch address (word-addressed).
REQ-011 SHALL have `if_id_instr`, output, 16, latched instruction.
REQ-012 SHALL have `if_id_pc`, output, 16, PC of the latched instruction.
REQ-013 SHALL have `if_id_valid`, output, 1, latched instruction is real (not NOP/flushed).
REQ-014 SHALL have `if_id_rn1` and `if_id_rn2`, output, 4 each, equal to `if_id_instr[7:4]` and `if_id_instr[3:0]`, fed back to hazard detection.
REQ-015 SHALL have `idex_bubble`, output, 1, zeroes ID/EX control signals this cycle.
REQ-016 SHALL have `stall_cnt`, output, 16, count of stalled cycles, saturating.

Function
REQ-017 SHALL update PC each edge with priority flush > stall > advance: `flush` → `branch_target`; else `pc_write`=1 → `pc_out`+1 (wraps 16'hFFFF→0); else hold.
REQ-018 SHALL load IF/ID when `flush`=1: `if_id_instr`=16'h0000 (NOP), `if_id_valid`=0, `if_id_pc` holds.
REQ-019 SHALL, when `flush`=0 and `IFIDWrite`&&`EnIW`, load `instr_in`→`if_id_instr`, `pc_out`→`if_id_pc`, and `if_id_valid`=1.
REQ-020 SHALL, otherwise, hold all IF/ID fields.
REQ-021 SHALL drive `idex_bubble` combinationally = `ST` || !`if_id_valid` || (state==FLUSH).
REQ-022 SHALL implement FSM states RUN, STALL, FLUSH.
REQ-023 SHALL transition from any state to FLUSH when `flush`=1.
REQ-024 SHALL, with `flush`=0, transition to STALL when `pc_write`=0, otherwise to RUN.
REQ-025 SHALL leave FLUSH after exactly one cycle unless `flush` is reasserted.
REQ-026 SHALL increment `stall_cnt` on every edge where next state is STALL, saturating at 16'hFFFF.
REQ-027 SHALL give simultaneous `flush` and stall inputs the flush behaviour and not count a stall.
REQ-028 SHALL add no extra latency: instruction at `pc_out` in cycle N appears on `if_id_instr` in cycle N+1.

Reset
REQ-029 SHALL force, on `rst_n`=0 (asynchronous, any cycle including mid-stall or mid-flush): `pc_out`=0, `if_id_instr`=16'h0000, `if_id_pc`=0, `if_id_valid`=0, state=RUN, `stall_cnt`=0.
REQ-030 SHALL make the first fetch from address 0 on the first edge after `rst_n` deasserts.

Structure
REQ-031 SHALL take the NOP encoding, instruction field positions, and FSM state encodings from the shared CPU package.
REQ-032 SHALL use one sub-module, `pc_reg` (16-bit PC with load/increment/hold), with the rest inline.

Verification
REQ-033 Reset then free run, `pc_write`=`IFIDWrite`=`EnIW`=1, imem[i]=i+16'h1000 → `pc_out` 0,1,2,…; `if_id_instr` 16'h1000,16'h1001,… one cycle later; `if_id_valid`=1 from cycle 1.
REQ-034 Load-use stall: `pc_write`=`IFIDWrite`=0, `ST`=1 for one cycle at `pc_out`=5 → `pc_out` stays 5, IF/ID holds, `idex_bubble`=1, `stall_cnt`=1, resumes at 6.
REQ-035 Flush: `flush`=1, `branch_target`=16'h0040 → next `pc_out`=16'h0040, `if_id_instr`=16'h0000, `if_id_valid`=0, `idex_bubble`=1 that cycle.
REQ-036 Flush and stall in the same cycle → flush behaviour only; `stall_cnt` unchanged.
REQ-037 `stall_cnt` preloaded near 16'hFFFF by a long stall → saturates at 16'hFFFF; PC wraps 16'hFFFF→0 on advance.
REQ-038 `rst_n` asserted mid-stall, asynchronously between edges → all outputs reach reset values immediately, with no clock edge required.
